// File: rtl/gamma_bus_ctrl.sv
// Gamma table controller: loads a 768-entry table from the host download port onto the mixer gamma bus.
// Optional GAMMA_RAMP_INIT_EN: writes a linear ramp after reset and holds off downloads with ioctl_wait.
module gamma_bus_ctrl #(
  parameter logic [7:0] GAMMA_INDEX = 8'd3
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [9:0]  ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  input  logic        gamma_user_en,
  inout  wire  [21:0] gamma_bus,
  output logic        gamma_supported,
  output logic        table_valid,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_PEND = 2'd2,
    ST_LOAD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  seq_q, seq_d;
  logic        tv_q, tv_d;
  logic        wr_q, wr_d;
  logic [9:0]  addr_q, addr_d;
  logic [7:0]  value_q, value_d;
  logic        gamma_en_q, gamma_en_d;
  logic        busy_q, busy_d;
  logic        dl_prev_q;
  logic        start_s, fall_s, wr_ok_s;

`ifdef GAMMA_RAMP_INIT_EN
  logic [9:0]  cnt_q, cnt_d;
  logic        wait_q, wait_d;
  logic        init_q, init_d;
  assign ioctl_wait = wait_q;
`else
  assign ioctl_wait = 1'b0;
`endif

  assign gamma_supported = gamma_bus[21];
  assign gamma_bus[20:0] = {clk_sys, gamma_en_q, wr_q, addr_q, value_q};
  assign table_valid     = tv_q;
  assign busy            = busy_q;

  assign start_s = ioctl_download & ~dl_prev_q & (ioctl_index == GAMMA_INDEX);
  assign fall_s  = ~ioctl_download & dl_prev_q;
  assign wr_ok_s = ioctl_wr & ~ioctl_wait & (ioctl_addr < 10'd768);

  // Next-state and bus-write decode
  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    tv_d    = tv_q;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    value_d = value_q;
`ifdef GAMMA_RAMP_INIT_EN
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    init_d  = init_q;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef GAMMA_RAMP_INIT_EN
        if (init_q) begin
          // A download already active at reset release is held off until the ramp is done
          state_d = ST_RAMP;
          init_d  = 1'b0;
          cnt_d   = 10'd0;
          wait_d  = start_s;
        end else if (start_s) begin
          state_d = ST_LOAD;
          tv_d    = 1'b0;
          seq_d   = 10'd0;
        end else begin
          state_d = ST_IDLE;
        end
`else
        if (start_s) begin
          state_d = ST_LOAD;
          tv_d    = 1'b0;
          seq_d   = 10'd0;
        end else begin
          state_d = ST_IDLE;
        end
`endif
      end
      ST_LOAD: begin
        if (wr_ok_s) begin
          wr_d    = 1'b1;
          addr_d  = ioctl_addr;
          value_d = ioctl_dout;
          if (ioctl_addr == seq_q) begin
            seq_d = seq_q + 10'd1;
          end else begin
            seq_d = seq_q;
          end
        end else begin
          wr_d = 1'b0;
        end
        // seq_d already includes a byte written in the same cycle as the falling edge
        if (fall_s) begin
          tv_d    = (seq_d == 10'd768);
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LOAD;
        end
      end
`ifdef GAMMA_RAMP_INIT_EN
      ST_RAMP: begin
        wr_d    = 1'b1;
        addr_d  = cnt_q;
        value_d = cnt_q[7:0];
        if (start_s) begin
          wait_d = 1'b1;
        end else if (fall_s) begin
          wait_d = 1'b0;
        end else begin
          wait_d = wait_q;
        end
        if (cnt_q == 10'd767) begin
          tv_d    = 1'b1;
          cnt_d   = 10'd0;
          state_d = wait_d ? ST_PEND : ST_IDLE;
        end else begin
          cnt_d   = cnt_q + 10'd1;
          state_d = ST_RAMP;
        end
      end
      ST_PEND: begin
        tv_d    = 1'b0;
        seq_d   = 10'd0;
        wait_d  = 1'b0;
        state_d = ioctl_download ? ST_LOAD : ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    gamma_en_d = gamma_user_en & tv_q & gamma_supported & (state_q == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      seq_q      <= 10'd0;
      tv_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= 10'd0;
      value_q    <= 8'd0;
      gamma_en_q <= 1'b0;
      busy_q     <= 1'b0;
      dl_prev_q  <= 1'b0;
`ifdef GAMMA_RAMP_INIT_EN
      cnt_q      <= 10'd0;
      wait_q     <= 1'b0;
      init_q     <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      seq_q      <= seq_d;
      tv_q       <= tv_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      value_q    <= value_d;
      gamma_en_q <= gamma_en_d;
      busy_q     <= busy_d;
      dl_prev_q  <= ioctl_download;
`ifdef GAMMA_RAMP_INIT_EN
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      init_q     <= init_d;
`endif
    end
  end

endmodule

// File: doc/gamma_bus_ctrl.md
GAMMA_BUS_CTRL -- requirements
Module: gamma_bus_ctrl

Interface
REQ-001 SHALL have parameter GAMMA_INDEX, default 8'd3, the ioctl_index value that selects a gamma table download.
REQ-002 SHALL have one clock, and reset is synchronous and active-high: clk_sys  in  1  system clock; reset  in  1  synchronous active-high reset.
REQ-003 SHALL have port ioctl_download  in  1  high while a host download is in progress.
REQ-004 SHALL have port ioctl_index  in  8  download target index.
REQ-005 SHALL have port ioctl_wr  in  1  single-cycle byte write strobe.
REQ-006 SHALL have port ioctl_addr  in  10  byte address within the download.
REQ-007 SHALL have port ioctl_dout  in  8  byte data.
REQ-008 SHALL have port ioctl_wait  out  1  host must not strobe ioctl_wr while this is high.
REQ-009 SHALL have port gamma_user_en  in  1  OSD gamma enable.
REQ-010 SHALL have port gamma_bus  inout  22  mixer gamma bus; bit 21 is read, bits 20:0 are driven.
REQ-011 SHALL have port gamma_supported  out  1  equals gamma_bus[21].
REQ-012 SHALL have port table_valid  out  1  the complete 768-entry table is loaded.
REQ-013 SHALL have port busy  out  1  high in RAMP, LOAD or PEND.

Function
REQ-014 SHALL drive gamma_bus as follows: [20] = clk_sys (combinational), [19] = gamma_en, [18] = wr, [17:8] = addr, [7:0] = value. All except [20] SHALL be registered.
REQ-015 SHALL use states IDLE, RAMP, PEND and LOAD.
REQ-016 SHALL register gamma_en = gamma_user_en & table_valid & gamma_supported & (state == IDLE), with 1-cycle latency.
REQ-017 SHALL define a download start as a rising edge of ioctl_download while ioctl_index == GAMMA_INDEX. A rising edge with any other index SHALL be ignored.
REQ-018 SHALL, on a download start in IDLE, enter LOAD in the next cycle, clear table_valid and clear the 10-bit seq counter.
REQ-019 SHALL, in LOAD, respond to ioctl_wr with ioctl_addr < 768 by producing wr = 1 for exactly one cycle in the next cycle, with addr = ioctl_addr and value = ioctl_dout.
REQ-020 SHALL ignore ioctl_wr with ioctl_addr >= 768: no bus write and no counter change.
REQ-021 SHALL increment seq only when ioctl_addr == seq. An out-of-order or duplicate byte SHALL still be written but SHALL NOT advance seq.
REQ-022 SHALL, on a falling edge of ioctl_download in LOAD, set table_valid = (seq == 768) and return to IDLE. An ioctl_wr in that same cycle SHALL be processed and counted first.
REQ-023 SHALL, in RAMP, write one entry per cycle from a counter running 0..767, with addr = cnt and value = cnt[7:0], then set table_valid = 1 and go to IDLE after the 768th write.
REQ-024 SHALL, on a download start during RAMP, raise ioctl_wait in the next cycle and move to PEND once RAMP completes. PEND SHALL then behave as LOAD entry: clear table_valid and seq, drop ioctl_wait, and enter LOAD.
REQ-025 SHALL ignore ioctl_wr while ioctl_wait is high.
REQ-026 SHALL continue to sequence bus writes when gamma_supported = 0, but gamma_en SHALL stay 0.
REQ-027 SHALL produce at most one wr pulse per cycle. wr SHALL be 0 in IDLE and PEND.

Reset
REQ-028 SHALL, while reset is high, hold wr = 0, addr = 0, value = 0, gamma_en = 0, table_valid = 0, ioctl_wait = 0, busy = 0 and state = IDLE, with all counters at 0.
REQ-029 SHALL treat reset during RAMP, PEND or LOAD as an abort: no further writes, table_valid = 0, any pending download discarded.
REQ-030 SHALL sample the edge detectors' previous ioctl_download value as 0 during reset, so a download already high at release counts as a start.

Configuration
REQ-031 SHALL support macro GAMMA_RAMP_INIT_EN. When it is defined, the first cycle after reset release SHALL enter RAMP, with busy = 1.
REQ-032 SHALL, when GAMMA_RAMP_INIT_EN is undefined, omit RAMP and PEND. After reset the block SHALL stay in IDLE with table_valid = 0 until a complete download, and ioctl_wait SHALL be tied to 0.

Verification
REQ-033 SHALL cover, with the macro defined: release reset -> 768 consecutive wr cycles addr 0..767, value = addr[7:0]; then table_valid = 1 and busy = 0.
REQ-034 SHALL cover, after the ramp with gamma_user_en = 1 and gamma_bus[21] = 1: gamma_en = 1 one cycle later. Driving gamma_bus[21] = 0 -> gamma_en = 0 one cycle later.
REQ-035 SHALL cover a download with index 3 and bytes at addr 0..767 -> each wr one cycle after ioctl_wr with matching addr and value; on the falling edge, table_valid = 1 and gamma_en returns to 1.
REQ-036 SHALL cover a download that skips addr 500 (767 bytes) -> table_valid = 0 and gamma_en = 0 after the falling edge. A byte at addr 800 -> no wr.
REQ-037 SHALL cover a download start at ramp cycle 100 -> ioctl_wait = 1 until the ramp ends, then PEND then LOAD; an ioctl_wr issued during wait produces no wr.
REQ-038 SHALL cover reset asserted mid-LOAD after 300 bytes -> all outputs at reset values next cycle, and table_valid = 0.
